// File: rtl/nf10_upb_packet_fifo_arbiter_if.sv
// ---------------------------------------------------------------------------
// nf10_upb_packet_fifo_arbiter_if
//   Bundles the FIFO read side and the AXI4-Stream output of the packet FIFO
//   arbiter.
//
//   FIFO read side (first-word-fall-through, one lane per port):
//     FIFO_EMPTY [NUM_PORTS]                 head word absent when 1
//     FIFO_EOP   [NUM_PORTS]                 head word ends its packet
//     FIFO_DO    [NUM_PORTS*DATA_WIDTH]      head data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//     FIFO_MO    [NUM_PORTS*METADATA_WIDTH]  head-packet metadata, same packing
//     FIFO_RDEN  [NUM_PORTS]                 pop strobe, at most one bit set
//   Stream side:
//     M_TDATA / M_TUSER / M_TLAST / M_TVALID / M_TREADY
//
//   Handshake: a beat transfers on a rising CLK edge where M_TVALID and
//   M_TREADY are both 1. Once M_TVALID is 1 it stays 1, with M_TDATA, M_TUSER
//   and M_TLAST unchanged, until that transfer happens. A FIFO pops on a
//   rising edge where its FIFO_RDEN bit is 1; RDEN is never raised for an
//   empty FIFO.
//
//   master: the arbiter's view.  slave: the FIFOs + downstream view.
// ---------------------------------------------------------------------------
interface nf10_upb_packet_fifo_arbiter_if #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 256,
  parameter int METADATA_WIDTH = 16
);
  logic [NUM_PORTS-1:0]                FIFO_EMPTY;
  logic [NUM_PORTS-1:0]                FIFO_EOP;
  logic [NUM_PORTS*DATA_WIDTH-1:0]     FIFO_DO;
  logic [NUM_PORTS*METADATA_WIDTH-1:0] FIFO_MO;
  logic [NUM_PORTS-1:0]                FIFO_RDEN;
  logic [DATA_WIDTH-1:0]               M_TDATA;
  logic [METADATA_WIDTH-1:0]           M_TUSER;
  logic                                M_TLAST;
  logic                                M_TVALID;
  logic                                M_TREADY;

  modport master (
    input  FIFO_EMPTY, FIFO_EOP, FIFO_DO, FIFO_MO, M_TREADY,
    output FIFO_RDEN, M_TDATA, M_TUSER, M_TLAST, M_TVALID
  );

  modport slave (
    output FIFO_EMPTY, FIFO_EOP, FIFO_DO, FIFO_MO, M_TREADY,
    input  FIFO_RDEN, M_TDATA, M_TUSER, M_TLAST, M_TVALID
  );
endinterface

// File: rtl/nf10_upb_packet_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// nf10_upb_packet_fifo_arbiter
//   Packet-granular round-robin scheduler. Drains NUM_PORTS FWFT packet FIFOs
//   into one AXI4-Stream master, one whole packet at a time, through a
//   registered output stage.
//
//   Ports:
//     CLK        clock
//     RST        synchronous, active-high reset
//     bus        nf10_upb_packet_fifo_arbiter_if.master (FIFO read side + stream)
//     GRANT      one-hot port being drained, 0 while idle
//     BUSY       a packet is being drained or a beat is still held
//     DBG_STATE  0 = IDLE, 1 = XFER
// ---------------------------------------------------------------------------
module nf10_upb_packet_fifo_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 256,
  parameter int METADATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  nf10_upb_packet_fifo_arbiter_if.master bus,
  output logic [NUM_PORTS-1:0]  GRANT,
  output logic                  BUSY,
  output logic                  DBG_STATE
);

  localparam int SW = $clog2(NUM_PORTS);
  localparam logic [SW:0]   NP_W     = (SW+1)'(NUM_PORTS);
  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_PORTS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t        state;
  logic [SW-1:0] sel;
  logic [SW-1:0] rr_ptr;

  // Round-robin scan: candidate k is (rr_ptr + k) mod NUM_PORTS. Walking k
  // downwards and overwriting leaves the lowest k (nearest rr_ptr) as winner.
  logic          scan_found;
  logic [SW-1:0] scan_idx;
  logic [SW:0]   cand;

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (SW+1)'(k);
      if (cand >= NP_W) cand = cand - NP_W;
      if (!bus.FIFO_EMPTY[cand[SW-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = cand[SW-1:0];
      end
    end
  end

  // Head word of the selected FIFO.
  logic                      head_empty;
  logic                      head_eop;
  logic [DATA_WIDTH-1:0]     head_do;
  logic [METADATA_WIDTH-1:0] head_mo;

  always_comb begin
    head_empty = 1'b1;
    head_eop   = 1'b0;
    head_do    = '0;
    head_mo    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SW'(i)) begin
        head_empty = bus.FIFO_EMPTY[i];
        head_eop   = bus.FIFO_EOP[i];
        head_do    = bus.FIFO_DO[i*DATA_WIDTH +: DATA_WIDTH];
        head_mo    = bus.FIFO_MO[i*METADATA_WIDTH +: METADATA_WIDTH];
      end
    end
  end

  // Pop whenever the output register is free or being emptied this cycle.
  // RST gates the strobe so nothing is consumed while the block is held.
  logic pop;
  assign pop = (state == S_XFER) && !head_empty &&
               (!bus.M_TVALID || bus.M_TREADY) && !RST;

  always_comb begin
    bus.FIFO_RDEN      = '0;
    bus.FIFO_RDEN[sel] = pop;
  end

  always_comb begin
    GRANT = '0;
    if (state == S_XFER) GRANT[sel] = 1'b1;
  end

  assign BUSY      = (state == S_XFER) || bus.M_TVALID;
  assign DBG_STATE = (state == S_XFER);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      sel          <= '0;
      rr_ptr       <= '0;
      bus.M_TVALID <= 1'b0;
      bus.M_TLAST  <= 1'b0;
      bus.M_TDATA  <= '0;
      bus.M_TUSER  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scan_found) begin
            sel   <= scan_idx;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          // An empty FIFO mid-packet just stalls; the port is never switched.
          if (pop && head_eop) begin
            state  <= S_IDLE;
            rr_ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (pop) begin
        bus.M_TDATA  <= head_do;
        bus.M_TUSER  <= head_mo;
        bus.M_TLAST  <= head_eop;
        bus.M_TVALID <= 1'b1;
      end else if (bus.M_TVALID && bus.M_TREADY) begin
        bus.M_TVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert ($onehot0(bus.FIFO_RDEN));
      assert ((bus.FIFO_RDEN & bus.FIFO_EMPTY) == '0);
    end
  end

  assert property (@(posedge CLK) disable iff (RST)
    (bus.M_TVALID && !bus.M_TREADY) |=> bus.M_TVALID);

endmodule

// File: tb/tb_nf10_upb_packet_fifo_arbiter.sv
module tb_nf10_upb_packet_fifo_arbiter;
  localparam int NP = 4;
  localparam int DW = 256;
  localparam int MW = 16;
  localparam int WW = 1 + MW + DW;  // {eop, mo, data}

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  nf10_upb_packet_fifo_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .METADATA_WIDTH(MW)) bus ();
  logic [NP-1:0] grant;
  logic          busy;
  logic          dbg_state;

  nf10_upb_packet_fifo_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .METADATA_WIDTH(MW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .GRANT(grant), .BUSY(busy), .DBG_STATE(dbg_state)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WW-1:0] fifo_q[NP][$];
  logic [WW-1:0] exp_q[$];
  int            exp_port_q[$];
  int            m_rr = 0;
  logic [NP-1:0] pop_pend = '0;
  int  rdy_mode = 0;        // 0: always ready, 1: random, 2: scripted stall
  int  pkt_beat = 0;        // beats accepted so far in the current packet
  int  stall_cnt = 0;
  bit  prev_hold = 0;
  logic [WW-1:0] prev_word;
  int            acc_port_q[$];
  int            acc_cyc_q[$];
  logic [WW-1:0] acc_word_q[$];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit fifos_empty();
    for (int i = 0; i < NP; i++) if (fifo_q[i].size() != 0) return 0;
    return 1;
  endfunction

  // ---------------- FIFO model (drivers) ----------------
  task automatic drive_fifo();
    logic [WW-1:0] w;
    for (int i = 0; i < NP; i++) begin
      if (fifo_q[i].size() > 0) begin
        w = fifo_q[i][0];
        bus.FIFO_EMPTY[i] = 1'b0;
        bus.FIFO_EOP[i]   = w[WW-1];
        bus.FIFO_MO[i*MW +: MW] = w[DW +: MW];
        bus.FIFO_DO[i*DW +: DW] = w[DW-1:0];
      end else begin
        bus.FIFO_EMPTY[i] = 1'b1;
        bus.FIFO_EOP[i]   = 1'b0;
        bus.FIFO_MO[i*MW +: MW] = '0;
        bus.FIFO_DO[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic load_pkt(input int port, input int len, input logic [MW-1:0] mo);
    logic [DW-1:0] d;
    for (int b = 0; b < len; b++) begin
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
      d[DW-1 -: 8]  = 8'(port);
      d[DW-9 -: 8]  = 8'(b);
      fifo_q[port].push_back({(b == len - 1), mo, d});
    end
    drive_fifo();
  endtask

  // Reference: with every queued packet present at once, whole packets come
  // out in round-robin order starting at the port after the last one served.
  task automatic build_exp();
    logic [WW-1:0] cp[NP][$];
    logic [WW-1:0] w;
    int f;
    bit done;
    for (int i = 0; i < NP; i++) cp[i] = fifo_q[i];
    done = 0;
    while (!done) begin
      f = -1;
      for (int k = 0; k < NP; k++) begin
        if (f < 0 && cp[(m_rr + k) % NP].size() > 0) f = (m_rr + k) % NP;
      end
      if (f < 0) done = 1;
      else begin
        do begin
          w = cp[f].pop_front();
          exp_q.push_back(w);
          exp_port_q.push_back(f);
        end while (!w[WW-1]);
        m_rr = (f + 1) % NP;
      end
    end
  endtask

  task automatic clear_logs();
    acc_port_q.delete();
    acc_cyc_q.delete();
    acc_word_q.delete();
  endtask

  // Pops land just after the edge that consumed them.
  always @(posedge CLK) begin
    cyc++;
    #1;
    for (int i = 0; i < NP; i++)
      if (pop_pend[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    pop_pend = '0;
    drive_fifo();
  end

  // ---------------- ready driver + scoreboard compare ----------------
  always @(negedge CLK) begin
    logic [WW-1:0] cur;
    logic [WW-1:0] e;
    case (rdy_mode)
      1: bus.M_TREADY = ($urandom_range(0, 3) != 0);
      2: begin
        if (bus.M_TVALID && (pkt_beat == 1 || pkt_beat == 2) && stall_cnt < 3) begin
          bus.M_TREADY = 1'b0;
          stall_cnt++;
        end else bus.M_TREADY = 1'b1;
      end
      default: bus.M_TREADY = 1'b1;
    endcase
    #1;
    cur = {bus.M_TLAST, bus.M_TUSER, bus.M_TDATA};
    if (RST) begin
      check("rden_in_reset", WW'(bus.FIFO_RDEN), '0);
      prev_hold = 0;
    end else begin
      if (bus.FIFO_RDEN != '0) begin
        check("rden_onehot", WW'($onehot(bus.FIFO_RDEN)), 1);
        check("grant_eq_rden", WW'(grant), WW'(bus.FIFO_RDEN));
        for (int i = 0; i < NP; i++) begin
          if (bus.FIFO_RDEN[i]) begin
            check("rden_nonempty", WW'(fifo_q[i].size() > 0), 1);
            if (exp_port_q.size() == 0) check("rden_unexpected", WW'(i), WW'(NP));
            else check("rden_port", WW'(i), WW'(exp_port_q.pop_front()));
          end
        end
        pop_pend = bus.FIFO_RDEN;
      end
      if (bus.M_TVALID && !bus.M_TREADY) check("no_rden_stall", WW'(bus.FIFO_RDEN), '0);
      check("busy", WW'(busy), WW'((grant != '0) || bus.M_TVALID));
      check("grant_onehot0", WW'($onehot0(grant)), 1);
      if (prev_hold) begin
        check("hold_valid", WW'(bus.M_TVALID), 1);
        check("hold_word", cur, prev_word);
      end
      if (bus.M_TVALID && bus.M_TREADY) begin
        if (exp_q.size() == 0) check("beat_unexpected", cur, '0);
        else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        acc_port_q.push_back(int'(bus.M_TDATA[DW-1 -: 8]));
        acc_cyc_q.push_back(cyc);
        acc_word_q.push_back(cur);
        stall_cnt = 0;
        if (bus.M_TLAST) pkt_beat = 0;
        else pkt_beat++;
      end
      prev_hold = bus.M_TVALID && !bus.M_TREADY;
      prev_word = cur;
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      @(negedge CLK);
      #2;
      n++;
      if (exp_q.size() == 0 && !busy && fifos_empty()) done = 1;
    end
    check({name, "_drained"}, WW'(done), 1);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int load_cyc;
    int n;
    int exp_order3[8];
    logic [WW-1:0] w5[4];

    bus.M_TREADY = 1'b1;
    drive_fifo();

    // Reset with every FIFO non-empty: nothing moves, then port 0 first.
    for (int i = 0; i < NP; i++) load_pkt(i, 1, MW'(16'h1000 + i));
    m_rr = 0;
    build_exp();
    clear_logs();
    repeat (2) begin
      @(negedge CLK);
      #2;
      check("rst_valid", WW'(bus.M_TVALID), 0);
      check("rst_rden", WW'(bus.FIFO_RDEN), 0);
      check("rst_grant", WW'(grant), 0);
    end
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #2;
    check("first_grant", WW'(grant), WW'(4'b0001));
    wait_drain(100, "t1");
    check("t1_count", WW'(acc_port_q.size()), 4);
    for (int i = 0; i < acc_port_q.size() && i < 4; i++) check("t1_order", WW'(acc_port_q[i]), WW'(i));

    // Two single-beat packets per port: 0,1,2,3,0,1,2,3 with one idle cycle.
    clear_logs();
    @(negedge CLK);
    for (int i = 0; i < NP; i++) begin
      load_pkt(i, 1, MW'(16'h3000 + i));
      load_pkt(i, 1, MW'(16'h3100 + i));
    end
    build_exp();
    wait_drain(200, "t3");
    exp_order3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    check("t3_count", WW'(acc_port_q.size()), 8);
    for (int i = 0; i < acc_port_q.size() && i < 8; i++) check("t3_order", WW'(acc_port_q[i]), WW'(exp_order3[i]));
    for (int i = 1; i < acc_cyc_q.size(); i++) check("t3_gap", WW'(acc_cyc_q[i] - acc_cyc_q[i-1]), 2);

    // Single port 2, 3 beats, BEEF metadata, back-to-back beats.
    clear_logs();
    @(negedge CLK);
    load_cyc = cyc;
    load_pkt(2, 3, 16'hBEEF);
    build_exp();
    @(posedge CLK);
    @(negedge CLK);
    #2;
    check("t2_grant", WW'(grant), WW'(4'b0100));
    wait_drain(100, "t2");
    check("t2_count", WW'(acc_word_q.size()), 3);
    if (acc_word_q.size() == 3) begin
      check("t2_latency", WW'(acc_cyc_q[0] - load_cyc), 2);
      for (int i = 0; i < 3; i++) begin
        check("t2_tuser", WW'(acc_word_q[i][DW +: MW]), WW'(16'hBEEF));
        check("t2_tlast", WW'(acc_word_q[i][WW-1]), WW'(i == 2));
        if (i > 0) check("t2_consecutive", WW'(acc_cyc_q[i] - acc_cyc_q[i-1]), 1);
      end
    end

    // rr_ptr now 3: port 3 goes first, then the pointer wraps to port 0.
    clear_logs();
    @(negedge CLK);
    load_pkt(0, 1, MW'(16'h4000));
    load_pkt(3, 1, MW'(16'h4003));
    build_exp();
    wait_drain(100, "t4");
    check("t4_count", WW'(acc_port_q.size()), 2);
    if (acc_port_q.size() == 2) begin
      check("t4_first", WW'(acc_port_q[0]), 3);
      check("t4_second", WW'(acc_port_q[1]), 0);
    end

    // 4-beat packet with 3-cycle stalls on beats 2 and 3.
    clear_logs();
    rdy_mode = 2;
    stall_cnt = 0;
    @(negedge CLK);
    load_pkt(1, 4, MW'(16'h5151));
    for (int i = 0; i < 4; i++) w5[i] = fifo_q[1][i];
    build_exp();
    wait_drain(100, "t5");
    check("t5_count", WW'(acc_word_q.size()), 4);
    if (acc_word_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t5_word", acc_word_q[i], w5[i]);
      check("t5_span", WW'(acc_cyc_q[3] - acc_cyc_q[0]), 9);
    end

    // Randomized batches with random back-pressure.
    rdy_mode = 1;
    for (int b = 0; b < 25; b++) begin
      @(negedge CLK);
      for (int i = 0; i < NP; i++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) load_pkt(i, $urandom_range(1, 5), MW'($urandom));
      end
      build_exp();
      wait_drain(600, "rand");
    end

    // Reset after beat 2 of a 5-beat packet drops the rest.
    rdy_mode = 0;
    clear_logs();
    @(negedge CLK);
    load_pkt(0, 5, MW'(16'h6060));
    build_exp();
    n = 0;
    while (acc_port_q.size() < 2 && n < 20) begin
      @(negedge CLK);
      #2;
      n++;
    end
    check("t6_two_beats", WW'(acc_port_q.size()), 2);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    #2;
    check("t6_valid", WW'(bus.M_TVALID), 0);
    check("t6_state", WW'(dbg_state), 0);
    check("t6_grant", WW'(grant), 0);
    for (int i = 0; i < NP; i++) fifo_q[i].delete();
    exp_q.delete();
    exp_port_q.delete();
    m_rr = 0;
    pkt_beat = 0;
    drive_fifo();
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      #2;
      check("t6_no_rden", WW'(bus.FIFO_RDEN), 0);
      check("t6_idle_valid", WW'(bus.M_TVALID), 0);
    end
    check("t6_total_beats", WW'(acc_port_q.size()), 2);

    check("final_exp_empty", WW'(exp_q.size()), 0);
    finish_sim();
  end

endmodule
